// File: rtl/prbs_gen_chk_if.sv
// Control, generator and checker bundle for prbs_gen_chk.
// master drives stimulus/controls, slave is the PRBS block.
interface prbs_gen_chk_if #(
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 16
) ();
  logic [1:0]           mode;
  logic                 gen_en;
  logic                 inj_err;
  logic [DATA_W-1:0]    gen_data;
  logic                 gen_valid;
  logic                 chk_en;
  logic [DATA_W-1:0]    chk_data;
  logic                 err_clr;
  logic                 locked;
  logic                 err_word;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output mode,
    output gen_en,
    output inj_err,
    output chk_en,
    output chk_data,
    output err_clr,
    input  gen_data,
    input  gen_valid,
    input  locked,
    input  err_word,
    input  err_cnt
  );

  modport slave (
    input  mode,
    input  gen_en,
    input  inj_err,
    input  chk_en,
    input  chk_data,
    input  err_clr,
    output gen_data,
    output gen_valid,
    output locked,
    output err_word,
    output err_cnt
  );
endinterface

// File: rtl/prbs_gen_chk.sv
// PRBS7/15/23/31 word generator and self-synchronising checker
// with lock FSM, error injection and saturating error counter.
module prbs_gen_chk #(
  parameter int DATA_W     = 8,
  parameter int ERR_CNT_W  = 16,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4
) (
  input logic           clk,
  input logic           rst_n,
  prbs_gen_chk_if.slave bus
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);
  localparam int PC_W   = $clog2(DATA_W + 1);
  localparam int SUM_W  = ERR_CNT_W + PC_W + 1;

  localparam logic [DATA_W-1:0] MSB_M =
    DATA_W'(1) << (DATA_W - 1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [GOOD_W-1:0] GOOD_LAST =
    GOOD_W'(LOCK_CNT - 1);
  localparam logic [BAD_W-1:0] BAD_LAST =
    BAD_W'(UNLOCK_CNT - 1);

  typedef enum logic {
    HUNT,
    LOCK
  } st_e;

  function automatic logic tap(
    input logic [30:0] s,
    input logic [1:0]  m
  );
    logic t;
    t = s[6] ^ s[5];
    case (m)
      2'd0:    t = s[6] ^ s[5];
      2'd1:    t = s[14] ^ s[13];
      2'd2:    t = s[22] ^ s[17];
      default: t = s[30] ^ s[27];
    endcase
    return t;
  endfunction

  function automatic logic [30:0] seed(
    input logic [1:0] m
  );
    logic [30:0] v;
    v = 31'h0000_007F;
    case (m)
      2'd0:    v = 31'h0000_007F;
      2'd1:    v = 31'h0000_7FFF;
      2'd2:    v = 31'h007F_FFFF;
      default: v = 31'h7FFF_FFFF;
    endcase
    return v;
  endfunction

  logic [1:0]           mode_q;
  logic                 mchg;

  logic [30:0]          gen_lfsr_q;
  logic [30:0]          gen_lfsr_d;
  logic [DATA_W-1:0]    gen_data_q;
  logic [DATA_W-1:0]    gen_data_d;
  logic                 gen_valid_q;
  logic                 gen_valid_d;

  logic [30:0]          chk_lfsr_q;
  logic [30:0]          chk_lfsr_d;
  st_e                  state_q;
  st_e                  state_d;
  logic [GOOD_W-1:0]    good_q;
  logic [GOOD_W-1:0]    good_d;
  logic [BAD_W-1:0]     bad_q;
  logic [BAD_W-1:0]     bad_d;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_d;
  logic                 err_word_q;
  logic                 err_word_d;

  logic [30:0]          gen_nxt;
  logic [DATA_W-1:0]    gen_word;
  logic [30:0]          chk_nxt;
  logic [DATA_W-1:0]    mism;
  logic [PC_W-1:0]      pc;
  logic [SUM_W-1:0]     sum;

  assign mchg = (bus.mode != mode_q);

  always_comb begin : gen_steps
    logic [30:0] s;
    logic        b;
    s        = gen_lfsr_q;
    b        = 1'b0;
    gen_word = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      b           = tap(s, mode_q);
      gen_word[i] = b;
      s           = {s[29:0], b};
    end
    gen_nxt = s;
  end

  // HUNT feeds received bits back; LOCK free-runs on prediction
  always_comb begin : chk_steps
    logic [30:0] s;
    logic        p;
    logic        fb;
    s    = chk_lfsr_q;
    p    = 1'b0;
    fb   = 1'b0;
    mism = '0;
    pc   = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      p       = tap(s, mode_q);
      mism[i] = p ^ bus.chk_data[i];
      fb      = (state_q == LOCK) ? p
                                  : bus.chk_data[i];
      s       = {s[29:0], fb};
      pc      = pc + PC_W'(mism[i]);
    end
    chk_nxt = s;
  end

  assign sum = SUM_W'(err_cnt_q) + SUM_W'(pc);

  always_comb begin : gen_next
    gen_lfsr_d  = gen_lfsr_q;
    gen_data_d  = gen_data_q;
    gen_valid_d = 1'b0;
    if (mchg) begin
      gen_lfsr_d = seed(bus.mode);
    end else if (bus.gen_en) begin
      gen_lfsr_d  = gen_nxt;
      gen_data_d  = bus.inj_err ? (gen_word ^ MSB_M)
                                : gen_word;
      gen_valid_d = 1'b1;
    end
  end

  always_comb begin : chk_fsm
    state_d    = state_q;
    good_d     = good_q;
    bad_d      = bad_q;
    chk_lfsr_d = chk_lfsr_q;
    err_cnt_d  = err_cnt_q;
    err_word_d = 1'b0;
    if (mchg) begin
      chk_lfsr_d = seed(bus.mode);
      state_d    = HUNT;
      good_d     = '0;
      bad_d      = '0;
    end else if (bus.chk_en) begin
      chk_lfsr_d = chk_nxt;
      unique case (state_q)
        HUNT: begin
          if (|mism) begin
            good_d = '0;
          end else if (good_q == GOOD_LAST) begin
            state_d = LOCK;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            good_d = good_q + GOOD_W'(1);
          end
        end
        LOCK: begin
          err_word_d = |mism;
          if (sum > SUM_W'(CNT_MAX)) begin
            err_cnt_d = CNT_MAX;
          end else begin
            err_cnt_d = sum[ERR_CNT_W-1:0];
          end
          if (!(|mism)) begin
            bad_d = '0;
          end else if (bad_q == BAD_LAST) begin
            state_d = HUNT;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            bad_d = bad_q + BAD_W'(1);
          end
        end
      endcase
    end
    if (bus.err_clr) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= 2'd0;
      gen_lfsr_q  <= 31'h0000_007F;
      gen_data_q  <= '0;
      gen_valid_q <= 1'b0;
      chk_lfsr_q  <= 31'h0000_007F;
      state_q     <= HUNT;
      good_q      <= '0;
      bad_q       <= '0;
      err_cnt_q   <= '0;
      err_word_q  <= 1'b0;
    end else begin
      mode_q      <= bus.mode;
      gen_lfsr_q  <= gen_lfsr_d;
      gen_data_q  <= gen_data_d;
      gen_valid_q <= gen_valid_d;
      chk_lfsr_q  <= chk_lfsr_d;
      state_q     <= state_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      err_cnt_q   <= err_cnt_d;
      err_word_q  <= err_word_d;
    end
  end

  assign bus.gen_data  = gen_data_q;
  assign bus.gen_valid = gen_valid_q;
  assign bus.locked    = (state_q == LOCK);
  assign bus.err_word  = err_word_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: doc/prbs_gen_chk.md
# prbs_gen_chk

Parametrised PRBS generator and self-synchronising checker for link and pad bring-up. Successor to the fixed single-bit PRBS source: selectable polynomial (PRBS7/15/23/31), DATA_W bits per cycle, error injection, and a checker with lock FSM and saturating error counter. Sits between the top-level pin wrapper and the pads: `gen_data` drives output pins, and `chk_data` is sampled from input pins or a loopback.

## Interface
- `DATA_W`, default 8: bits generated/checked per clock, 1..32.
- `ERR_CNT_W`, default 16: width of error counter.
- `LOCK_CNT`, default 16: consecutive clean words needed to lock, ≥2.
- `UNLOCK_CNT`, default 4: consecutive errored words needed to lose lock, ≥1.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `mode` in 2: polynomial select.
  - 0: PRBS7, x^7+x^6+1.
  - 1: PRBS15, x^15+x^14+1.
  - 2: PRBS23, x^23+x^18+1.
  - 3: PRBS31, x^31+x^28+1.
- `gen_en` in 1: advance generator one word.
- `inj_err` in 1: invert earliest bit of the word generated this cycle; sampled only when `gen_en`.
- `gen_data` out DATA_W: generated word; MSB is earliest bit in time.
- `gen_valid` out 1: `gen_data` updated this cycle.
- `chk_en` in 1: `chk_data` valid this cycle.
- `chk_data` in DATA_W: received word, MSB earliest.
- `err_clr` in 1: synchronous clear of `err_cnt`.
- `locked` out 1: checker in LOCK.
- `err_word` out 1: pulse, the last checked word (LOCK only) had ≥1 mismatch.
- `err_cnt` out ERR_CNT_W: saturating count of mismatched bits in LOCK.

## Operation
**LFSR model**
- 31-bit Fibonacci state `s`, with only the low N bits significant (N = 7/15/23/31).
- One step: new = s[a-1]^s[b-1] for taps (a,b) = (7,6)/(15,14)/(23,18)/(31,28). Shift left, insert new at s[0]. The output bit is new.
- One word = DATA_W steps in one cycle. The earliest step maps to the word MSB.

**Generator**
- Reset/reseed: state = all-ones in the low N bits.
- On `gen_en`, the state advances DATA_W steps and `gen_data` is loaded with those bits.
- With `inj_err`, `gen_data[DATA_W-1]` is inverted. The LFSR state itself is not corrupted.

**Checker FSM, states HUNT and LOCK**
- HUNT:
  - Each `chk_en` word is predicted from the checker state. The received bits, not the predicted ones, are shifted into the state (self-synchronising).
  - Clean word: `good_cnt`++. Any mismatch: `good_cnt`=0.
  - Clean word with `good_cnt`==LOCK_CNT-1: go to LOCK, `bad_cnt`=0.
  - No error counting in HUNT.
- LOCK:
  - The state free-runs on predicted bits, so one line error counts as exactly one bit.
  - `err_cnt` += popcount(mismatch), saturating at all-ones. `err_word`=1 if popcount>0.
  - Errored word: `bad_cnt`++. Clean word: `bad_cnt`=0.
  - Errored word with `bad_cnt`==UNLOCK_CNT-1: go to HUNT, `good_cnt`=0. That word's errors are still counted.
- Without `chk_en`: the FSM, counters and state hold, and `err_word`=0.

**Mode change**
- `mode` is registered. Any cycle where the registered value differs from the input:
  - both LFSRs reseed;
  - checker goes to HUNT with `good_cnt`=0;
  - that cycle's `gen_en`/`chk_en` work is discarded;
  - `gen_valid`=0.
- `err_cnt` is kept.

**Error counter clear**
- `err_clr` zeroes `err_cnt`. If an error occurs in the same cycle, clear wins and the error is dropped.

## Timing
- Reset values:
  - `gen_data`=0, `gen_valid`=0, `locked`=0, `err_word`=0, `err_cnt`=0.
  - State HUNT; all internal counters 0; both LFSRs seeded; registered mode=0.
- Generator latency: `gen_en` at edge t → `gen_data`/`gen_valid` valid after edge t. `gen_valid` = registered `gen_en`, except in mode-change cycles.
- Checker latency: `chk_data` sampled at edge t → `err_word`, `err_cnt`, `locked` reflect that word after edge t.
- Reset mid-operation: all outputs return to reset values asynchronously. The first post-reset `gen_en` produces the seed-derived first word.
- All DATA_W steps are combinational within one cycle. No multicycle paths.

## Test plan
1. **Generator start:** DATA_W=8, mode=0, reset, then `gen_en`=1.
   - First word = 0x02 (bit sequence 0,0,0,0,0,0,1,0).
   - The stream repeats with period 127 bits and matches the software model for modes 0–3.
2. **Loopback lock:** `chk_data`=`gen_data` delayed one cycle, `chk_en`=`gen_valid`.
   - `locked` rises after exactly LOCK_CNT clean words following the first word that fills the state.
   - `err_cnt` stays 0 for 10k words.
3. **Error injection:** while locked, three `inj_err` pulses on separate words.
   - `err_cnt`=3, `err_word` pulses three times, `locked` stays 1.
4. **Loss of lock:** while locked, force `chk_data`=~expected for UNLOCK_CNT words.
   - `locked` falls after word UNLOCK_CNT; `err_cnt` = 8·UNLOCK_CNT.
   - After `chk_data` is restored, relock occurs after LOCK_CNT clean words.
5. **Saturation/clear:** ERR_CNT_W=4, continuous single-bit errors with UNLOCK_CNT large.
   - `err_cnt` holds at 15.
   - `err_clr` coincident with an error → 0 next cycle, then 1 on the following errored word.
6. **Mode change and reset:**
   - Switch mode 0→3 mid-stream: `gen_valid`=0 for one cycle, `locked`→0, then the PRBS31 seed sequence starts.
   - Assert `rst_n`=0 mid-word: all outputs read 0 before the next edge.
